ddma_tx_injector: RTL and testbench

DMA-side transmitter that drives packets into a router local port through the DDMA end of the router port interface (clock_rx, rx, data_i out; credit_o in). A host pushes payload flits into an internal FIFO, then issues a start command with destination and size; the block emits header flit, size flit and payload flits under the router's credit-based flow control. It sits between the DDMA control logic and the router's local input port.

---
 rtl/ddma_tx_injector.sv | 176 +++++++++++++++++
 tb/tb_ddma_tx_injector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddma_tx_injector.sv
// ddma_tx_injector: DDMA-side packet transmitter into a router local port.
// A host fills a payload FIFO and then issues start with dest/size. The block
// sends a header flit, a size flit and the payload flits under credit flow control.
// Optional feature macro: DDMA_TX_OVF_EN. When it is defined, ovf is a sticky flag
// for dropped FIFO writes. When it is undefined, ovf is tied low.
module ddma_tx_injector #(
    parameter int FLIT_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          clock_rx,
    output logic                          rx,
    output logic [FLIT_WIDTH-1:0]         data_i,
    input  logic                          credit_o,
    input  logic                          fifo_wr,
    input  logic [FLIT_WIDTH-1:0]         fifo_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          start,
    input  logic [FLIT_WIDTH-1:0]         dest,
    input  logic [FLIT_WIDTH-1:0]         size,
    output logic                          busy,
    output logic                          done,
    output logic                          ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, HEADER, SIZE, PAYLOAD, DONE} state_t;

    state_t                state_q, state_n;
    logic                  rx_q, rx_n;
    logic [FLIT_WIDTH-1:0] data_q, data_n;
    logic [FLIT_WIDTH-1:0] rem_q, rem_n;
    logic [FLIT_WIDTH-1:0] rem_left;
    logic [FLIT_WIDTH-1:0] size_q;

    logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count_q;
    logic                  fifo_empty, push, pop, avail, xfer;
    logic [FLIT_WIDTH-1:0] head;

    assign clock_rx   = clock;
    assign rx         = rx_q;
    assign data_i     = data_q;
    assign fifo_count = count_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign busy       = (state_q == HEADER) || (state_q == SIZE) || (state_q == PAYLOAD);
    assign done       = (state_q == DONE);

    // A write into a full FIFO is dropped, even if a pop happens on the same edge.
    assign push  = fifo_wr && !fifo_full;
    // An empty FIFO forwards the incoming write straight to the output.
    // This lets an underrun recover on the cycle right after the write.
    assign avail = !fifo_empty || push;
    assign head  = fifo_empty ? fifo_data : mem[rd_ptr];
    assign xfer  = rx_q && credit_o;
    assign rem_left = xfer ? rem_q - FLIT_WIDTH'(1) : rem_q;

    // Payload storage: write port only
    // NOTE: the array has no reset; the pointers and the count define its valid contents.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= fifo_data;
    end

    // FIFO pointers and occupancy count
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state, next-output and FIFO pop decision
    // NOTE: every output gets a default first, so no latches are inferred.
    always_comb begin
        state_n = state_q;
        rx_n    = rx_q;
        data_n  = data_q;
        rem_n   = rem_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rx_n    = 1'b1;
                    data_n  = dest;
                    rem_n   = size;
                    state_n = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    data_n  = size_q;
                    state_n = SIZE;
                end
            end
            SIZE: begin
                if (xfer) begin
                    if (rem_q == '0) begin
                        rx_n    = 1'b0;
                        state_n = DONE;
                    end else begin
                        state_n = PAYLOAD;
                        if (avail) begin
                            pop    = 1'b1;
                            rx_n   = 1'b1;
                            data_n = head;
                        end else begin
                            rx_n = 1'b0;
                        end
                    end
                end
            end
            PAYLOAD: begin
                rem_n = rem_left;
                if (!rx_q || xfer) begin
                    if (rem_left == '0) begin
                        rx_n    = 1'b0;
                        state_n = DONE;
                    end else if (avail) begin
                        pop    = 1'b1;
                        rx_n   = 1'b1;
                        data_n = head;
                    end else begin
                        rx_n = 1'b0;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, output-slot and packet counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rx_q    <= 1'b0;
            data_q  <= '0;
            rem_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_n;
            rx_q    <= rx_n;
            data_q  <= data_n;
            rem_q   <= rem_n;
            if (state_q == IDLE && start) size_q <= size;
        end
    end

`ifdef DDMA_TX_OVF_EN
    logic ovf_q;
    // Sticky overflow: set by any dropped write, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                     ovf_q <= 1'b0;
        else if (fifo_wr && fifo_full) ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ddma_tx_injector.sv
// Self-checking bench for ddma_tx_injector (FLIT_WIDTH=16, FIFO_DEPTH=16).
// Table-driven packet sequences plus hand-written corner-case sequences.
module tb_ddma_tx_injector;

    logic        clock = 1'b0;
    logic        reset;
    logic        clock_rx;
    logic        rx;
    logic [15:0] data_i;
    logic        credit_o;
    logic        fifo_wr;
    logic [15:0] fifo_data;
    logic        fifo_full;
    logic [4:0]  fifo_count;
    logic        start;
    logic [15:0] dest;
    logic [15:0] size;
    logic        busy;
    logic        done;
    logic        ovf;

    int total  = 0;
    int passed = 0;

    ddma_tx_injector #(.FLIT_WIDTH(16), .FIFO_DEPTH(16)) dut (
        .clock(clock), .reset(reset), .clock_rx(clock_rx), .rx(rx), .data_i(data_i),
        .credit_o(credit_o), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .start(start), .dest(dest),
        .size(size), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clock = ~clock;

    // One row per cycle: the credit driven in that cycle and the outputs expected in it
    typedef struct {
        logic        credit;
        logic        rx;
        logic [15:0] data;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

`ifdef DDMA_TX_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    function automatic void add(input logic c, input logic r, input logic [15:0] d,
                                input logic b, input logic dn);
        vecs.push_back('{credit: c, rx: r, data: d, busy: b, done: dn});
    endfunction

    task automatic push(input logic [15:0] d);
        @(negedge clock);
        fifo_wr   = 1'b1;
        fifo_data = d;
        @(negedge clock);
        fifo_wr   = 1'b0;
    endtask

    task automatic issue_start(input logic [15:0] d, input logic [15:0] s);
        @(negedge clock);
        start    = 1'b1;
        dest     = d;
        size     = s;
        credit_o = 1'b1;
    endtask

    task automatic run_vecs(input string tag, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clock);
            start    = 1'b0;
            credit_o = vecs[i].credit;
            check($sformatf("%s[%0d].rx", tag, i - lo), rx, vecs[i].rx);
            if (vecs[i].rx) check($sformatf("%s[%0d].data", tag, i - lo), data_i, vecs[i].data);
            check($sformatf("%s[%0d].busy", tag, i - lo), busy, vecs[i].busy);
            check($sformatf("%s[%0d].done", tag, i - lo), done, vecs[i].done);
        end
    endtask

    // Watchdog for the whole run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t1_lo, t1_hi, t2_lo, t2_hi, t3_lo, t3_hi;

        // Test 1: plain packet. Header, size, four payload flits, done, idle.
        t1_lo = vecs.size();
        add(1, 1, 16'h0011, 1, 0);
        add(1, 1, 16'h0004, 1, 0);
        for (int k = 0; k < 4; k++) add(1, 1, 16'h00A0 + 16'(k), 1, 0);
        add(1, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0000, 0, 0);
        t1_hi = vecs.size() - 1;
        // Test 2: credit is low for 3 cycles while the size flit is presented.
        t2_lo = vecs.size();
        add(1, 1, 16'h0011, 1, 0);
        add(0, 1, 16'h0004, 1, 0);
        add(0, 1, 16'h0004, 1, 0);
        add(0, 1, 16'h0004, 1, 0);
        add(1, 1, 16'h0004, 1, 0);
        for (int k = 0; k < 4; k++) add(1, 1, 16'h00A0 + 16'(k), 1, 0);
        add(1, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0000, 0, 0);
        t2_hi = vecs.size() - 1;
        // Test 3: size=0 packet. Header, zero size flit, then done.
        t3_lo = vecs.size();
        add(1, 1, 16'h0022, 1, 0);
        add(1, 1, 16'h0000, 1, 0);
        add(1, 0, 16'h0000, 0, 1);
        add(1, 0, 16'h0000, 0, 0);
        t3_hi = vecs.size() - 1;

        reset = 1'b1; credit_o = 1'b0; fifo_wr = 1'b0; fifo_data = '0;
        start = 1'b0; dest = '0; size = '0;
        repeat (2) @(negedge clock);
        check("rst.rx", rx, 0);
        check("rst.data", data_i, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.ovf", ovf, 0);
        check("rst.count", fifo_count, 0);
        check("rst.full", fifo_full, 0);
        check("clock_rx", clock_rx, clock);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) push(16'h00A0 + 16'(k));
        check("t1.count_pre", fifo_count, 4);
        issue_start(16'h0011, 16'd4);
        run_vecs("t1", t1_lo, t1_hi);
        check("t1.count_post", fifo_count, 0);

        for (int k = 0; k < 4; k++) push(16'h00A0 + 16'(k));
        issue_start(16'h0011, 16'd4);
        run_vecs("t2", t2_lo, t2_hi);

        push(16'h00B0);
        push(16'h00B1);
        issue_start(16'h0022, 16'd0);
        run_vecs("t3", t3_lo, t3_hi);
        check("t3.count_untouched", fifo_count, 2);

        // Flush the leftover flits before the underrun test
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        check("flush.count", fifo_count, 0);

        // Test 4: underrun. Each flit appears the cycle after its write.
        issue_start(16'h0033, 16'd3);
        @(negedge clock); start = 1'b0;
        check("t4.hdr", data_i, 16'h0033);
        @(negedge clock);
        check("t4.size", data_i, 16'h0003);
        for (int k = 0; k < 3; k++) begin
            repeat (4) begin
                @(negedge clock);
                check($sformatf("t4.stall%0d.rx", k), rx, 0);
                check($sformatf("t4.stall%0d.busy", k), busy, 1);
            end
            @(negedge clock); fifo_wr = 1'b1; fifo_data = 16'h00C0 + 16'(k);
            @(negedge clock); fifo_wr = 1'b0;
            check($sformatf("t4.flit%0d.rx", k), rx, 1);
            check($sformatf("t4.flit%0d.data", k), data_i, 16'h00C0 + 16'(k));
        end
        @(negedge clock);
        check("t4.done", done, 1);
        check("t4.rx_low", rx, 0);

        // Test 5: overflow. Fill 16 flits, then a 17th write of 0xFF is dropped.
        check("t5.empty", fifo_count, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clock); fifo_wr = 1'b1; fifo_data = 16'h00D0 + 16'(k);
        end
        @(negedge clock); fifo_data = 16'h00FF;
        @(negedge clock); fifo_wr = 1'b0;
        check("t5.full", fifo_full, 1);
        check("t5.count", fifo_count, 16);
        check("t5.ovf", ovf, EXP_OVF);
        issue_start(16'h0055, 16'd16);
        @(negedge clock); start = 1'b0;
        check("t5.hdr", data_i, 16'h0055);
        @(negedge clock);
        check("t5.size", data_i, 16'd16);
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check($sformatf("t5.p%0d", k), {15'd0, rx, data_i}, {15'd0, 1'b1, 16'h00D0 + 16'(k)});
        end
        @(negedge clock);
        check("t5.done", done, 1);
        check("t5.count_post", fifo_count, 0);
        @(negedge clock);
        check("t5.no_ff", rx, 0);

        // Test 6: reset mid-packet after two payload flits, then a fresh packet.
        for (int k = 0; k < 6; k++) push(16'h00E0 + 16'(k));
        issue_start(16'h0066, 16'd6);
        @(negedge clock); start = 1'b0;
        check("t6.hdr", data_i, 16'h0066);
        repeat (3) @(negedge clock);
        check("t6.p1", data_i, 16'h00E1);
        @(negedge clock);
        check("t6.p2", data_i, 16'h00E2);
        reset = 1'b1;
        #1;
        check("t6.rst.rx", rx, 0);
        check("t6.rst.data", data_i, 0);
        check("t6.rst.busy", busy, 0);
        check("t6.rst.done", done, 0);
        check("t6.rst.count", fifo_count, 0);
        check("t6.rst.full", fifo_full, 0);
        check("t6.rst.ovf", ovf, 0);
        @(negedge clock); reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("t6.no_done", {rx, done}, 2'b00);
        end
        push(16'h0070);
        push(16'h0071);
        issue_start(16'h0077, 16'd2);
        @(negedge clock); start = 1'b0;
        check("t6.new.hdr", {rx, data_i}, {1'b1, 16'h0077});
        @(negedge clock);
        check("t6.new.size", {rx, data_i}, {1'b1, 16'h0002});
        @(negedge clock);
        check("t6.new.p0", {rx, data_i}, {1'b1, 16'h0070});
        @(negedge clock);
        check("t6.new.p1", {rx, data_i}, {1'b1, 16'h0071});
        @(negedge clock);
        check("t6.new.done", done, 1);
        check("t6.new.count", fifo_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
